// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and default width for the sequential multiplier
package mul_seq_pkg;
    localparam int MUL_WIDTH = 32;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/add_N_bit.sv
// add_N_bit: N-bit ripple-carry adder, carry-in zero, carry-out dropped
module add_N_bit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    logic [N-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-and-add unsigned multiplier, one shared adder over WIDTH cycles
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [2*WIDTH-1:0]   p_reg;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    assign acc     = {1'b0, p_reg[2*WIDTH-1:WIDTH]};
    assign addend  = p_reg[0] ? {1'b0, a_reg} : '0;
    assign product = p_reg;
    // one bit wider than the operands so each partial sum keeps its carry
    add_N_bit #(.N(WIDTH + 1)) u_add (
        .a  (acc),
        .b  (addend),
        .sum(sum)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            p_reg     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid && in_ready) begin
                    a_reg    <= op_a;
                    p_reg    <= {{WIDTH{1'b0}}, op_b};
                    cnt      <= '0;
                    state    <= S_RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                S_RUN: begin
                    p_reg <= {sum, p_reg[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for the sequential multiplier at WIDTH=8 and WIDTH=32
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  op_a8 = '0, op_b8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;
    logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
    logic [31:0] op_a32 = '0, op_b32 = '0;
    logic        in_ready32, out_valid32, busy32;
    logic [63:0] product32;
    logic [15:0] exp8[$];
    logic [63:0] exp32[$];
    int checks = 0;
    int passed = 0;
    always #5 clk = ~clk;
    mul_seq_ctrl #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );
    mul_seq_ctrl #(.WIDTH(32)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .op_a(op_a32), .op_b(op_b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .product(product32), .busy(busy32)
    );
    task automatic accept8(input logic [7:0] a, input logic [7:0] b);
        in_valid8 = 1'b1;
        op_a8 = a;
        op_b8 = b;
        exp8.push_back(16'(a) * 16'(b));
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask
    task automatic wait_out8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, busy8, product8} !== {3'b100, 16'd0})
            $display("FAIL reset8 got rdy/vld/busy/prod=%b%b%b/%0h want 100/0", in_ready8, out_valid8, busy8, product8);
        else passed++;
        checks++;
        if ({in_ready32, out_valid32, busy32, product32} !== {3'b100, 64'd0})
            $display("FAIL reset32 got rdy/vld/busy/prod=%b%b%b/%0h want 100/0", in_ready32, out_valid32, busy32, product32);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_product(input logic [7:0] a, input logic [7:0] b, input string name);
        int lat;
        logic [15:0] e;
        out_ready8 = 1'b1;
        checks++;
        if (in_ready8 !== 1'b1) $display("FAIL %s idle_ready got %b want 1", name, in_ready8);
        else passed++;
        accept8(a, b);
        checks++;
        if ({busy8, in_ready8, out_valid8} !== 3'b100)
            $display("FAIL %s run_flags got busy/rdy/vld=%b%b%b want 100", name, busy8, in_ready8, out_valid8);
        else passed++;
        wait_out8(lat);
        checks++;
        if (lat !== 8) $display("FAIL %s latency got %0d want 8", name, lat);
        else passed++;
        e = exp8.pop_front();
        checks++;
        if (product8 !== e) $display("FAIL %s product got %0d want %0d", name, product8, e);
        else passed++;
        @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, busy8} !== 3'b100)
            $display("FAIL %s after_hs got rdy/vld/busy=%b%b%b want 100", name, in_ready8, out_valid8, busy8);
        else passed++;
    endtask
    task automatic test_backpressure;
        int lat;
        logic [15:0] e;
        out_ready8 = 1'b0;
        accept8(8'd13, 8'd11);
        wait_out8(lat);
        checks++;
        if (lat !== 8) $display("FAIL bp latency got %0d want 8", lat);
        else passed++;
        e = exp8.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid8, in_ready8, product8} !== {2'b10, e})
                $display("FAIL bp hold%0d got vld/rdy/prod=%b%b/%0d want 10/%0d", i, out_valid8, in_ready8, product8, e);
            else passed++;
            in_valid8 = 1'b1;
            op_a8 = 8'(i + 2);
            op_b8 = 8'(i + 40);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, busy8, product8} !== {3'b100, e})
            $display("FAIL bp release got rdy/vld/busy/prod=%b%b%b/%0d want 100/%0d", in_ready8, out_valid8, busy8, product8, e);
        else passed++;
    endtask
    task automatic test_async_reset;
        logic seen;
        out_ready8 = 1'b1;
        accept8(8'd100, 8'd100);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready8, out_valid8, busy8, product8} !== {3'b100, 16'd0})
            $display("FAIL areset got rdy/vld/busy/prod=%b%b%b/%0h want 100/0", in_ready8, out_valid8, busy8, product8);
        else passed++;
        exp8.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid8;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL areset stray_valid got %b want 0", seen);
        else passed++;
        test_product(8'd7, 8'd9, "post_reset");
    endtask
    task automatic test_back_to_back;
        int cycle = 0, got = 0, sent = 0, last = -1;
        logic [63:0] e;
        while (got < 1000 && cycle < 60000) begin
            @(negedge clk);
            cycle++;
            in_valid32 = sent < 1000;
            if (in_ready32) begin
                op_a32 = $urandom;
                op_b32 = $urandom;
            end
            out_ready32 = 1'($urandom_range(0, 1));
            if (out_valid32 && out_ready32) begin
                checks++;
                if (exp32.size() == 0) $display("FAIL b2b unexpected product %0h", product32);
                else begin
                    e = exp32.pop_front();
                    if (product32 !== e) $display("FAIL b2b product%0d got %0h want %0h", got, product32, e);
                    else passed++;
                end
                got++;
            end
            if (in_valid32 && in_ready32) begin
                exp32.push_back(64'(op_a32) * 64'(op_b32));
                if (last >= 0) begin
                    checks++;
                    if (cycle - last < 34) $display("FAIL b2b interval got %0d want >=34", cycle - last);
                    else passed++;
                end
                last = cycle;
                sent++;
            end
        end
        in_valid32 = 1'b0;
        checks++;
        if (got !== 1000) $display("FAIL b2b count got %0d want 1000", got);
        else passed++;
    endtask
    initial begin
        test_reset;
        test_product(8'd3, 8'd5, "basic");
        test_product(8'd255, 8'd255, "carry");
        test_product(8'd0, 8'd200, "zero_a");
        test_product(8'd200, 8'd0, "zero_b");
        test_backpressure;
        test_async_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
